sprite_line_buffer: RTL and testbench

// Ping-pong pair of sprite line buffers between the sprite renderer and the composer. The renderer

---
 rtl/sprite_line_buffer_pkg.sv | 35 +++
 rtl/sprite_line_buffer_if.sv | 29 ++
 rtl/sprite_linebuf_ram.sv | 21 ++
 rtl/sprite_line_buffer.sv | 130 +++++++++++++
 tb/tb_sprite_line_buffer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_line_buffer_pkg.sv
// Shared sprite line-buffer types: entry layout {collision, 2'b0, z, color} and index width.
// The sprite renderer packs entries with the same field offsets.
package sprite_line_buffer_pkg;

  localparam int LINEBUF_DATA_W = 16;
  localparam int LINEBUF_IDX_W  = 10;
  localparam int LINEBUF_DEPTH  = 1 << LINEBUF_IDX_W;

  localparam int ENTRY_COLL_LSB  = 12;
  localparam int ENTRY_COLL_W    = 4;
  localparam int ENTRY_Z_LSB     = 8;
  localparam int ENTRY_Z_W       = 2;
  localparam int ENTRY_COLOR_LSB = 0;
  localparam int ENTRY_COLOR_W   = 8;

  typedef logic [LINEBUF_DATA_W-1:0] lb_entry_t;
  typedef logic [LINEBUF_IDX_W-1:0]  lb_idx_t;

  typedef enum logic {
    LB_INIT = 1'b0,
    LB_RUN  = 1'b1
  } lb_state_t;

  function automatic lb_entry_t make_entry(input logic [ENTRY_COLL_W-1:0]  coll,
                                           input logic [ENTRY_Z_W-1:0]     z,
                                           input logic [ENTRY_COLOR_W-1:0] color);
    lb_entry_t e;
    e = '0;
    e[ENTRY_COLL_LSB  +: ENTRY_COLL_W]  = coll;
    e[ENTRY_Z_LSB     +: ENTRY_Z_W]     = z;
    e[ENTRY_COLOR_LSB +: ENTRY_COLOR_W] = color;
    return e;
  endfunction

endpackage

// File: rtl/sprite_line_buffer_if.sv
// Renderer/composer port bundle of the sprite line buffer; master drives requests, slave is the buffer.
interface sprite_line_buffer_if;
  import sprite_line_buffer_pkg::*;

  logic      line_render_start;
  lb_idx_t   render_rdidx;
  lb_entry_t render_rddata;
  lb_idx_t   render_wridx;
  lb_entry_t render_wrdata;
  logic      render_wren;
  lb_idx_t   disp_rdidx;
  logic      disp_rden;
  lb_entry_t disp_rddata;
  logic      init_busy;
  logic      clear_underrun;

  modport master (
    output line_render_start, render_rdidx, render_wridx, render_wrdata, render_wren,
           disp_rdidx, disp_rden,
    input  render_rddata, disp_rddata, init_busy, clear_underrun
  );

  modport slave (
    input  line_render_start, render_rdidx, render_wridx, render_wrdata, render_wren,
           disp_rdidx, disp_rden,
    output render_rddata, disp_rddata, init_busy, clear_underrun
  );

endinterface

// File: rtl/sprite_linebuf_ram.sv
// 1024x16 line RAM, one write port and one registered read port.
// A read of the address being written in the same cycle returns the old entry.
module sprite_linebuf_ram
  import sprite_line_buffer_pkg::*;
(
  input  logic      clk,
  input  logic      we,
  input  lb_idx_t   waddr,
  input  lb_entry_t wdata,
  input  lb_idx_t   raddr,
  output lb_entry_t rdata
);

  lb_entry_t mem [LINEBUF_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sprite_line_buffer.sv
// Ping-pong sprite line buffer: the renderer read-modify-writes one bank while the composer reads-and-clears
// the other; both read ports have 1-cycle latency and a post-reset sweep zeroes both banks first.
module sprite_line_buffer
  import sprite_line_buffer_pkg::*;
#(
  parameter int LINE_WIDTH = 640
) (
  input logic                 clk,
  input logic                 rst,
  sprite_line_buffer_if.slave lb
);

  localparam logic [LINEBUF_IDX_W:0] WIDTH    = LINE_WIDTH[LINEBUF_IDX_W:0];
  localparam lb_idx_t                LAST_IDX = lb_idx_t'(LINE_WIDTH - 1);

  function automatic logic in_line(input lb_idx_t idx);
    return {1'b0, idx} < WIDTH;
  endfunction

  lb_state_t state;
  lb_idx_t   ptr;
  lb_idx_t   clr_cnt;
  lb_idx_t   clr_idx;
  logic      bank_r;
  logic      swapped;
  logic      init_busy_r;
  logic      underrun_r;
  logic      rnd_ok;
  logic      rnd_bank;
  logic      clr_pend;
  logic      clr_bank;
  lb_entry_t ram_q [2];

  logic    run;
  logic    wr_ok;
  logic    rd_ok;
  lb_idx_t cnt_next;

  assign run      = (state == LB_RUN);
  assign wr_ok    = run && lb.render_wren && in_line(lb.render_wridx);
  assign rd_ok    = run && lb.disp_rden && in_line(lb.disp_rdidx);
  assign cnt_next = clr_cnt + lb_idx_t'(rd_ok);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BANK = 1'(b);
    logic      we;
    lb_idx_t   waddr;
    lb_entry_t wdata;
    lb_idx_t   raddr;

    // A registered clear may land in the bank that just became the render bank; it owns the port then.
    always_comb begin
      we    = 1'b0;
      waddr = lb.render_wridx;
      wdata = lb.render_wrdata;
      raddr = (bank_r == BANK) ? lb.render_rdidx : lb.disp_rdidx;
      if (!run) begin
        we    = 1'b1;
        waddr = ptr;
        wdata = '0;
      end else if (clr_pend && clr_bank == BANK) begin
        we    = 1'b1;
        waddr = clr_idx;
        wdata = '0;
      end else if (wr_ok && bank_r == BANK) begin
        we    = 1'b1;
      end
    end

    sprite_linebuf_ram u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (ram_q[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LB_INIT;
      ptr         <= '0;
      init_busy_r <= 1'b1;
      bank_r      <= 1'b0;
      rnd_ok      <= 1'b0;
      rnd_bank    <= 1'b0;
      clr_pend    <= 1'b0;
      clr_bank    <= 1'b0;
      clr_idx     <= '0;
      clr_cnt     <= '0;
      swapped     <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      rnd_ok     <= run && in_line(lb.render_rdidx);
      rnd_bank   <= bank_r;
      clr_pend   <= rd_ok;
      clr_bank   <= ~bank_r;
      clr_idx    <= lb.disp_rdidx;
      underrun_r <= 1'b0;
      if (lb.line_render_start) bank_r <= ~bank_r;

      case (state)
        LB_INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_IDX) begin
            state       <= LB_RUN;
            init_busy_r <= 1'b0;
          end
        end
        LB_RUN: begin
          // A read issued in the swap cycle still belongs to the line being closed.
          if (lb.line_render_start) begin
            underrun_r <= swapped && ({1'b0, cnt_next} != WIDTH);
            swapped    <= 1'b1;
            clr_cnt    <= '0;
          end else begin
            clr_cnt <= cnt_next;
          end
        end
      endcase
    end
  end

  assign lb.render_rddata  = rnd_ok ? ram_q[rnd_bank] : '0;
  assign lb.disp_rddata    = clr_pend ? ram_q[clr_bank] : '0;
  assign lb.init_busy      = init_busy_r;
  assign lb.clear_underrun = underrun_r;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Bench for sprite_line_buffer: directed line scenarios plus randomized lines, every cycle compared
// against a line-level model of the two banks.
module tb_sprite_line_buffer;
  import sprite_line_buffer_pkg::*;

  localparam int LW = 640;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  sprite_line_buffer_if lb();

  sprite_line_buffer #(.LINE_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .lb  (lb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Banks hold line contents; a reset zeroes them outright, since nothing is observable until the sweep ends.
  logic [15:0] mbank [2][1024];
  bit          msel;
  int          init_left;
  bit          pend;
  bit          pend_bank;
  int          pend_idx;
  int          rd_count;
  bit          swapped;
  logic [15:0] e_rnd;
  logic [15:0] e_dsp;
  bit          e_busy;
  bit          e_under;
  bit          model_valid = 1'b0;

  initial begin
    bit run;
    bit rd_ok;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int b = 0; b < 2; b++)
          for (int i = 0; i < 1024; i++) mbank[b][i] = 16'h0;
        msel = 0; init_left = LW; pend = 0; rd_count = 0; swapped = 0;
        e_rnd = 0; e_dsp = 0; e_busy = 1; e_under = 0;
      end else begin
        run   = (init_left == 0);
        e_rnd = (run && lb.render_rdidx < LW) ? mbank[msel][lb.render_rdidx] : 16'h0;
        rd_ok = run && lb.disp_rden && lb.disp_rdidx < LW;
        e_dsp = rd_ok ? mbank[!msel][lb.disp_rdidx] : 16'h0;
        // Reads above see the line before this cycle's writes land.
        if (run && lb.render_wren && lb.render_wridx < LW) mbank[msel][lb.render_wridx] = lb.render_wrdata;
        if (pend) mbank[pend_bank][pend_idx] = 16'h0;
        pend      = rd_ok;
        pend_bank = !msel;
        pend_idx  = int'(lb.disp_rdidx);
        if (rd_ok) rd_count++;
        e_under = 0;
        if (lb.line_render_start) begin
          if (run) begin
            e_under  = swapped && (rd_count != LW);
            swapped  = 1;
            rd_count = 0;
          end
          msel = !msel;
        end
        if (init_left > 0) init_left--;
        e_busy = (init_left > 0);
      end
      model_valid = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        check("cycle render_rddata", lb.render_rddata, e_rnd);
        check("cycle disp_rddata", lb.disp_rddata, e_dsp);
        check("cycle init_busy", lb.init_busy, e_busy);
        check("cycle clear_underrun", lb.clear_underrun, e_under);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    lb.line_render_start = 1'b0;
    lb.render_wren       = 1'b0;
    lb.disp_rden         = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [15:0] data);
    lb.render_wren = 1'b1; lb.render_wridx = 10'(idx); lb.render_wrdata = data;
    @(negedge clk);
    lb.render_wren = 1'b0;
  endtask

  task automatic swap();
    lb.line_render_start = 1'b1;
    @(negedge clk);
    lb.line_render_start = 1'b0;
  endtask

  task automatic rd_disp(input string name, input int idx, input logic [15:0] exp);
    lb.disp_rden = 1'b1; lb.disp_rdidx = 10'(idx);
    @(negedge clk);
    lb.disp_rden = 1'b0;
    check(name, lb.disp_rddata, exp);
  endtask

  task automatic rd_both(input string name, input int idx);
    lb.disp_rden = 1'b1; lb.disp_rdidx = 10'(idx); lb.render_rdidx = 10'(idx);
    @(negedge clk);
    lb.disp_rden = 1'b0;
    check({name, " render"}, lb.render_rddata, 16'h0);
    check({name, " disp"}, lb.disp_rddata, 16'h0);
  endtask

  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    while (lb.init_busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check(name, n, LW);
  endtask

  task automatic read_span(input int count);
    for (int i = 0; i < count; i++) begin
      lb.disp_rden = 1'b1; lb.disp_rdidx = 10'(i);
      @(negedge clk);
    end
    lb.disp_rden = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit guard;
    bit full;
    int len;
    int cidx;
    rst = 1'b1;
    lb.render_rdidx = '0; lb.render_wridx = '0; lb.render_wrdata = '0;
    lb.disp_rdidx = '0;
    idle();
    repeat (3) @(negedge clk);
    check("reset init_busy", lb.init_busy, 1);
    check("reset render_rddata", lb.render_rddata, 0);
    check("reset disp_rddata", lb.disp_rddata, 0);
    check("reset clear_underrun", lb.clear_underrun, 0);

    // Sweep length and an all-empty display bank afterwards.
    rst = 1'b0;
    wait_sweep("init sweep cycles");
    for (int i = 0; i < LW; i++) rd_disp("empty after init", i, 16'h0);

    // Write, swap, read back; the read clears the entry.
    wr(5, make_entry(4'h1, 2'd2, 8'h03));
    swap();
    rd_disp("idx5 after swap", 5, 16'h1203);
    swap();
    swap();
    rd_disp("idx5 cleared", 5, 16'h0);

    // Out-of-range writes are dropped on both sides.
    wr(640, 16'hFFFF);
    wr(1023, 16'hFFFF);
    lb.render_rdidx = 10'd640;
    @(negedge clk);
    check("render read 640", lb.render_rddata, 0);
    swap();
    rd_disp("disp read 640", 640, 16'h0);
    rd_disp("disp read 1023", 1023, 16'h0);

    // Swap-cycle write goes to the old render bank; swap-cycle read clears in the old display bank.
    wr(9, 16'h0055);
    swap();
    lb.line_render_start = 1'b1;
    lb.render_wren = 1'b1; lb.render_wridx = 10'd7; lb.render_wrdata = 16'h00AA;
    lb.disp_rden = 1'b1; lb.disp_rdidx = 10'd9;
    @(negedge clk);
    idle();
    check("swap-cycle disp read 9", lb.disp_rddata, 16'h0055);
    @(negedge clk);
    lb.render_rdidx = 10'd9;
    lb.disp_rden = 1'b1; lb.disp_rdidx = 10'd7;
    @(negedge clk);
    lb.disp_rden = 1'b0;
    check("idx9 cleared in old bank", lb.render_rddata, 16'h0);
    check("idx7 via display bank", lb.disp_rddata, 16'h00AA);

    // Underrun: one short line flags exactly once, a complete line does not.
    swap();
    read_span(LW - 1);
    swap();
    check("underrun pulse", lb.clear_underrun, 1);
    @(negedge clk);
    check("underrun one cycle", lb.clear_underrun, 0);
    read_span(LW);
    swap();
    check("no underrun full line", lb.clear_underrun, 0);

    // Mid-line reset with data in both banks.
    wr(0, 16'h1111); wr(320, 16'h2222); wr(639, 16'h3333);
    swap();
    wr(0, 16'h4444); wr(320, 16'h5555); wr(639, 16'h6666);
    read_span(10);
    rst = 1'b1;
    @(negedge clk);
    check("mid-line reset init_busy", lb.init_busy, 1);
    @(negedge clk);
    rst = 1'b0;
    wait_sweep("re-init sweep cycles");
    rd_both("post-reset idx0", 0);
    rd_both("post-reset idx320", 320);
    rd_both("post-reset idx639", 639);

    // Randomized lines: even lines read the whole line, odd lines read sparsely and out of order.
    guard = 1'b0;
    for (int line = 0; line < 8; line++) begin
      len  = 650 + int'($urandom_range(0, 50));
      cidx = 0;
      full = (line % 2 == 0);
      for (int c = 0; c < len; c++) begin
        lb.line_render_start = (c == len - 1);
        lb.render_rdidx  = 10'($urandom_range(0, 1023));
        lb.render_wren   = !guard && ($urandom_range(0, 1) == 1);
        lb.render_wridx  = 10'($urandom_range(0, 699));
        lb.render_wrdata = 16'($urandom);
        if (full) begin
          lb.disp_rden  = (cidx < LW);
          lb.disp_rdidx = 10'(cidx);
          cidx++;
        end else begin
          lb.disp_rden  = ($urandom_range(0, 9) < 7);
          lb.disp_rdidx = 10'($urandom_range(0, 699));
        end
        // The clear of a swap-cycle read owns the new render bank's write port for one cycle.
        guard = lb.line_render_start && lb.disp_rden;
        @(negedge clk);
      end
    end
    idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
